l2_norm_vec_accum: RTL and testbench
====================================

# l2_norm_vec_accum

Parametrised sum-of-squares (squared L2 norm) engine for multi-lane input vectors. It accepts LANES samples per beat under a valid/ready handshake and squares each sample. Lane squares are summed and accumulated over a vector of up to VEC_LEN beats. At vector end it emits one saturating result with a beat count and a saturation flag under a second valid/ready handshake. It is the successor to the single-byte free-running square accumulator and sits between the sample front end and the norm/sqrt stage.

## Interface
- DATA_W, 8, sample width per lane.
- LANES, 2, samples per beat (≥1).
- VEC_LEN, 4, beats per vector (≥1).
- ACC_W, 20, result width; must be ≥ 2*DATA_W.
- SIGNED, 0, 0 = unsigned samples, 1 = two's-complement samples.
- Clock is clk. Reset is reset: asynchronous, active-high.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- clear  in  1  synchronous abort of the vector in progress.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready at a rising edge.
- in_data  in  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- in_last  in  1  marks the final beat when the vector is shorter than VEC_LEN.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  downstream accepts the result.
- out_sum  out  ACC_W  sum of squares of the vector, saturated.
- out_beats  out  $clog2(VEC_LEN+1)  beats in the vector.
- out_sat  out  1  set if saturation occurred anywhere in the vector.

## Operation
- Pipeline:
  - S1 registers the input beat, the last flag and the beat index.
  - S2 registers the lane sum of squares, width 2*DATA_W+$clog2(LANES) (minimum 1 extra bit).
  - S3 holds the accumulator and the output register.
- Squares:
  - SIGNED=0: each lane is an unsigned square.
  - SIGNED=1: each lane is sign-extended, then squared. The result is unsigned and fits 2*DATA_W, e.g. (-128)² = 16384.
- Beat counter increments on each accepted beat. A beat is last if in_last = 1 or the counter = VEC_LEN-1. The counter returns to 0 after a last beat.
- Accumulation: acc_next = acc + S2 sum.
  - If acc_next ≥ 2^ACC_W, the accumulator holds 2^ACC_W-1 and the sticky sat bit is set.
  - Once saturated, the accumulator stays at maximum for the rest of the vector.
- When S2 carries the last beat:
  - out_sum, out_beats and out_sat load the final values; out_valid is set.
  - Accumulator, sat bit and per-vector count clear to 0 in the same edge, so the next vector starts from 0 with no bubble.
- Stall rule: pipe_en = !(out_valid && !out_ready). All of S1–S3 advance only when pipe_en = 1.
- in_ready = pipe_en && !clear. This is a combinational path from out_ready to in_ready, and it is permitted.
- clear = 1 at an edge:
  - Beat counter, S1/S2 valid bits, accumulator and sat bit go to 0.
  - No input beat is accepted that cycle.
  - A result already pending in the output register stays pending and is unaffected.
- Output handshake: out_valid falls on the edge with out_ready = 1, unless a new result loads in the same edge. In that case out_valid stays 1 with the new data.

## Timing
- Reset values: in_ready = 0 while reset is asserted, and 1 in the first cycle after release if out_ready is don't-care. out_valid = 0, out_sum = 0, out_beats = 0, out_sat = 0. Accumulator, counter and pipeline valids are 0.
- Latency: the last beat is accepted at edge E; out_valid = 1 after edge E+2, with no stalls.
- Throughput is one beat per cycle. Back-to-back vectors are supported; a 1-beat vector (VEC_LEN=1 or in_last on beat 0) yields a result every cycle.
- Stall: while out_valid && !out_ready, all stages hold and in_ready = 0. No data is lost or duplicated.
- Reset asserted mid-vector: all state clears immediately (asynchronous). No partial result is ever emitted.
- A simultaneous clear and a last beat in S2: clear wins and no result is produced.

## Test plan
- Unsigned, default parameters. Beats (1,2), (3,4), (5,6), (7,8), out_ready = 1 → out_sum = 204, out_beats = 4, out_sat = 0, out_valid high 2 cycles after the 4th accept.
- Early termination. Beats (3,4) then (0,0) with in_last = 1 → out_sum = 25, out_beats = 2. The next vector of four (1,1) beats → 8.
- Saturation, ACC_W = 18. Four beats of (255,255) → out_sum = 262143, out_sat = 1. The following vector of (1,0)×4 → 4, out_sat = 0.
- SIGNED = 1, VEC_LEN = 1. Beat (-128,-1) → out_sum = 16385, out_beats = 1.
- Backpressure:
  - Setup: out_ready = 0; stream two vectors of (1,2) beats.
  - Expected: the first result 20 is held, in_ready = 0, pipeline frozen.
  - Raise out_ready: 20 then 20 are delivered, none dropped.
- Abort paths:
  - clear after 2 beats of (10,10), then 4 beats of (1,1) → single result 8.
  - reset pulsed mid-vector → all outputs 0 immediately; the next full vector is correct.

Source files
------------

// File: rtl/l2_norm_vec_accum.sv
// Squared L2 norm engine: squares LANES samples per beat and accumulates
// them over a vector of up to VEC_LEN beats, emitting one saturating result.
module l2_norm_vec_accum #(
    parameter int DATA_W  = 8,
    parameter int LANES   = 2,
    parameter int VEC_LEN = 4,
    parameter int ACC_W   = 20,
    parameter int SIGNED  = 0,
    localparam int CNT_W  = $clog2(VEC_LEN + 1)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ACC_W-1:0]          out_sum,
    output logic [CNT_W-1:0]          out_beats,
    output logic                      out_sat
);

    localparam int EXT_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int SUM_W = 2 * DATA_W + EXT_W;
    localparam int NXT_W = ((SUM_W > ACC_W) ? SUM_W : ACC_W) + 1;

    logic                    pipe_en;
    logic                    accept;
    logic                    is_last;
    logic [CNT_W-1:0]        cnt;

    logic                    s1_valid;
    logic [LANES*DATA_W-1:0] s1_data;
    logic                    s1_last;
    logic [CNT_W-1:0]        s1_idx;

    logic                    s2_valid;
    logic [SUM_W-1:0]        s2_sum;
    logic                    s2_last;
    logic [CNT_W-1:0]        s2_beats;

    logic [ACC_W-1:0]        acc;
    logic                    sat;

    logic [SUM_W-1:0]        lane_sum;
    logic [DATA_W-1:0]       smp;
    logic [DATA_W-1:0]       mag;
    logic [2*DATA_W-1:0]     sq;
    logic [NXT_W-1:0]        acc_sum;
    logic                    ovf;
    logic [ACC_W-1:0]        acc_nxt;
    logic                    load;

    // A held result freezes every stage so nothing is lost or duplicated.
    assign pipe_en  = !(out_valid && !out_ready);
    assign in_ready = pipe_en && !clear && !reset;
    assign accept   = in_valid && in_ready;
    assign is_last  = in_last || (cnt == CNT_W'(VEC_LEN - 1));
    assign load     = pipe_en && !clear && s2_valid && s2_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_last  <= 1'b0;
            s1_idx   <= '0;
        end else if (clear) begin
            cnt      <= '0;
            s1_valid <= 1'b0;
        end else if (pipe_en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_data <= in_data;
                s1_last <= is_last;
                s1_idx  <= cnt;
                cnt     <= is_last ? '0 : cnt + 1'b1;
            end
        end
    end

    // Signed lanes are squared via their magnitude; -2^(DATA_W-1) still fits.
    always_comb begin
        lane_sum = '0;
        smp      = '0;
        mag      = '0;
        sq       = '0;
        for (int i = 0; i < LANES; i++) begin
            smp      = s1_data[i*DATA_W +: DATA_W];
            mag      = (SIGNED != 0 && smp[DATA_W-1]) ? -smp : smp;
            sq       = {{DATA_W{1'b0}}, mag} * {{DATA_W{1'b0}}, mag};
            lane_sum = lane_sum + SUM_W'(sq);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_sum   <= '0;
            s2_last  <= 1'b0;
            s2_beats <= '0;
        end else if (clear) begin
            s2_valid <= 1'b0;
        end else if (pipe_en) begin
            s2_valid <= s1_valid;
            s2_sum   <= lane_sum;
            s2_last  <= s1_last;
            s2_beats <= s1_idx + 1'b1;
        end
    end

    always_comb begin
        acc_sum = NXT_W'(acc) + NXT_W'(s2_sum);
        ovf     = sat || (acc_sum >= (NXT_W'(1) << ACC_W));
        acc_nxt = ovf ? '1 : acc_sum[ACC_W-1:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            sat       <= 1'b0;
            out_sum   <= '0;
            out_beats <= '0;
            out_sat   <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            sat <= 1'b0;
        end else if (pipe_en && s2_valid) begin
            if (s2_last) begin
                out_sum   <= acc_nxt;
                out_beats <= s2_beats;
                out_sat   <= ovf;
                acc       <= '0;
                sat       <= 1'b0;
            end else begin
                acc <= acc_nxt;
                sat <= ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_l2_norm_vec_accum.sv
// Bench for l2_norm_vec_accum: three instances cover default, narrow-ACC
// saturation and signed single-beat configurations.
module tb_l2_norm_vec_accum;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [2:0]  iv, il, clr, ordy;
    logic [15:0] id [3];
    wire  [2:0]  ir, ov, osat;
    wire  [19:0] os [3];
    wire  [2:0]  ob [3];
    wire  [17:0] os1_w;
    wire         ob2_w;

    assign os[1] = {2'b00, os1_w};
    assign ob[2] = {2'b00, ob2_w};

    l2_norm_vec_accum dut0 (
        .clk(clk), .reset(reset), .clear(clr[0]),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_data(id[0]),
        .in_last(il[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
        .out_sum(os[0]), .out_beats(ob[0]), .out_sat(osat[0])
    );

    l2_norm_vec_accum #(.ACC_W(18)) dut1 (
        .clk(clk), .reset(reset), .clear(clr[1]),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_data(id[1]),
        .in_last(il[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
        .out_sum(os1_w), .out_beats(ob[1]), .out_sat(osat[1])
    );

    l2_norm_vec_accum #(.SIGNED(1), .VEC_LEN(1)) dut2 (
        .clk(clk), .reset(reset), .clear(clr[2]),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_data(id[2]),
        .in_last(il[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
        .out_sum(os[2]), .out_beats(ob[2]), .out_sat(osat[2])
    );

    typedef struct {
        logic [19:0] s;
        logic [2:0]  b;
        logic        sat;
    } res_t;

    typedef struct {
        int          k;
        logic [63:0] d;
        int          n;
        bit          early;
        logic [19:0] es;
        logic [2:0]  eb;
        bit          esat;
    } vec_t;

    res_t q0[$], q1[$], q2[$];
    int   n_chk = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        if (ov[0] && ordy[0]) q0.push_back('{os[0], ob[0], osat[0]});
        if (ov[1] && ordy[1]) q1.push_back('{os[1], ob[1], osat[1]});
        if (ov[2] && ordy[2]) q2.push_back('{os[2], ob[2], osat[2]});
    end

    function automatic int qsize(input int k);
        case (k)
            0: return q0.size();
            1: return q1.size();
            default: return q2.size();
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input int k, input logic [15:0] d,
                             input logic last);
        bit got;
        got   = 1'b0;
        iv[k] = 1'b1;
        id[k] = d;
        il[k] = last;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            got = ir[k];
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: inst %0d in_ready 0, expected 1", k);
        end
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
        il[k] = 1'b0;
    endtask

    task automatic get_res(input int k, input string nm,
                           input logic [19:0] es, input logic [2:0] eb,
                           input logic esat);
        res_t r;
        bit   ok;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            if (qsize(k) > 0) begin
                case (k)
                    0: r = q0.pop_front();
                    1: r = q1.pop_front();
                    default: r = q2.pop_front();
                endcase
                ok = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!ok) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: no result, expected sum %0d", nm, es);
        end else begin
            chk({nm, "_sum"}, r.s, es);
            chk({nm, "_beats"}, r.b, eb);
            chk({nm, "_sat"}, r.sat, esat);
        end
    endtask

    vec_t tbl [12];
    int   n;

    initial begin
        tbl[0]  = '{0, 64'h0807_0605_0403_0201, 4, 0, 20'd204, 3'd4, 0};
        tbl[1]  = '{0, 64'h0000_0000_0000_0403, 2, 1, 20'd25, 3'd2, 0};
        tbl[2]  = '{0, 64'h0101_0101_0101_0101, 4, 0, 20'd8, 3'd4, 0};
        tbl[3]  = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 4, 0, 20'd520200, 3'd4, 0};
        tbl[4]  = '{0, 64'h0000_0000_0000_000A, 1, 1, 20'd100, 3'd1, 0};
        tbl[5]  = '{0, 64'h0000_0000_0000_0000, 4, 0, 20'd0, 3'd4, 0};
        tbl[6]  = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 4, 0, 20'd262143, 3'd4, 1};
        tbl[7]  = '{1, 64'h0001_0001_0001_0001, 4, 0, 20'd4, 3'd4, 0};
        tbl[8]  = '{1, 64'h0000_0000_FFFF_FFFF, 2, 1, 20'd260100, 3'd2, 0};
        tbl[9]  = '{2, 64'h0000_0000_0000_FF80, 1, 0, 20'd16385, 3'd1, 0};
        tbl[10] = '{2, 64'h0000_0000_0000_817F, 1, 0, 20'd32258, 3'd1, 0};
        tbl[11] = '{2, 64'h0000_0000_0000_8080, 1, 1, 20'd32768, 3'd1, 0};

        reset = 1'b0;
        iv    = '0;
        il    = '0;
        clr   = '0;
        ordy  = 3'b111;
        for (int k = 0; k < 3; k++) id[k] = '0;
        #1 reset = 1'b1;
        #3;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d_in_ready", k), ir[k], 0);
            chk($sformatf("rst%0d_out_valid", k), ov[k], 0);
            chk($sformatf("rst%0d_out_sum", k), os[k], 0);
            chk($sformatf("rst%0d_out_beats", k), ob[k], 0);
            chk($sformatf("rst%0d_out_sat", k), osat[k], 0);
        end
        #18 reset = 1'b0;
        #1;
        for (int k = 0; k < 3; k++)
            chk($sformatf("rel%0d_in_ready", k), ir[k], 1);

        // Latency: result visible after the second edge past the last accept.
        sync();
        send_beat(0, 16'h0201, 1'b0);
        send_beat(0, 16'h0403, 1'b0);
        send_beat(0, 16'h0605, 1'b0);
        send_beat(0, 16'h0807, 1'b0);
        chk("lat_e0_valid", ov[0], 0);
        sync();
        chk("lat_e1_valid", ov[0], 0);
        sync();
        chk("lat_e2_valid", ov[0], 1);
        chk("lat_e2_sum", os[0], 204);
        get_res(0, "lat", 20'd204, 3'd4, 1'b0);

        for (int i = 0; i < 12; i++) begin
            sync();
            for (int j = 0; j < tbl[i].n; j++)
                send_beat(tbl[i].k, tbl[i].d[j*16 +: 16],
                          tbl[i].early && (j == tbl[i].n - 1));
            get_res(tbl[i].k, $sformatf("vec%0d", i),
                    tbl[i].es, tbl[i].eb, tbl[i].esat);
        end

        // Backpressure: two vectors of (1,2) with the sink stalled.
        sync();
        ordy[0] = 1'b0;
        iv[0]   = 1'b1;
        id[0]   = 16'h0201;
        il[0]   = 1'b0;
        n       = 0;
        repeat (12) begin
            @(negedge clk);
            if (ir[0]) n++;
        end
        chk("bp_accepts", n, 6);
        chk("bp_valid", ov[0], 1);
        chk("bp_sum", os[0], 20);
        chk("bp_in_ready", ir[0], 0);
        chk("bp_held", qsize(0), 0);
        sync();
        ordy[0] = 1'b1;
        for (int c = 0; c < 30 && n < 8; c++) begin
            @(negedge clk);
            if (ir[0]) n++;
        end
        sync();
        iv[0] = 1'b0;
        get_res(0, "bp_first", 20'd20, 3'd4, 1'b0);
        get_res(0, "bp_second", 20'd20, 3'd4, 1'b0);
        repeat (8) @(negedge clk);
        chk("bp_no_dup", qsize(0), 0);

        // Abort after two beats, then a clean vector.
        sync();
        send_beat(0, 16'h0A0A, 1'b0);
        send_beat(0, 16'h0A0A, 1'b0);
        clr[0] = 1'b1;
        #1;
        chk("clr_in_ready", ir[0], 0);
        sync();
        clr[0] = 1'b0;
        for (int j = 0; j < 4; j++) send_beat(0, 16'h0101, 1'b0);
        get_res(0, "clr", 20'd8, 3'd4, 1'b0);
        repeat (8) @(negedge clk);
        chk("clr_single", qsize(0), 0);

        // Clear coinciding with the last beat in S2 suppresses the result.
        sync();
        for (int j = 0; j < 4; j++) send_beat(0, 16'h0002, 1'b0);
        sync();
        clr[0] = 1'b1;
        sync();
        clr[0] = 1'b0;
        repeat (6) @(negedge clk);
        chk("clr_last_none", qsize(0), 0);
        chk("clr_last_valid", ov[0], 0);
        sync();
        send_beat(0, 16'h0005, 1'b1);
        get_res(0, "after_clr", 20'd25, 3'd1, 1'b0);

        // Asynchronous reset mid-vector.
        sync();
        send_beat(0, 16'h0909, 1'b0);
        send_beat(0, 16'h0909, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_sum", os[0], 0);
        chk("mid_rst_beats", ob[0], 0);
        chk("mid_rst_valid", ov[0], 0);
        chk("mid_rst_in_ready", ir[0], 0);
        #3 reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_rst_no_partial", qsize(0), 0);
        sync();
        send_beat(0, 16'h0201, 1'b0);
        send_beat(0, 16'h0403, 1'b0);
        send_beat(0, 16'h0605, 1'b0);
        send_beat(0, 16'h0807, 1'b0);
        get_res(0, "post_rst", 20'd204, 3'd4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
